// File: rtl/uart_sipo_rx.sv
// rtl/uart_sipo_rx.sv - UART receiver front end: oversampled start detect, LSB-first shift-in, parity/framing status (optional RX_MAJORITY_VOTE_EN)
module uart_sipo_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int              CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] s_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          armed_q;
    logic [1:0]    par_type_q;
    logic          par_bit_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;
    logic          rx_smp;
    logic          par_en;
    logic          par_exp;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    // Two cycles of line history so each sample point can vote 2-of-3
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign rx_smp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_smp = rx_s;
`endif

    // Parity modes 01 (odd) and 10 (even) are enabled; 00/11 mean no parity
    assign par_en  = ^par_type_q;
    assign par_exp = (par_type_q == 2'b10) ? ^shift_q : ~^shift_q;

    // Receive FSM: start validation at half bit, then one sample per bit period
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            s_cnt_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b0;
            par_type_q   <= 2'b00;
            par_bit_q    <= 1'b0;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q     <= S_START;
                        s_cnt_q     <= '0;
                        par_type_q  <= parity_type;
                        active_flag <= 1'b1;
                        done_flag   <= 1'b0;
                    end
                end
                S_START: begin
                    if (s_cnt_q == HALF_M1) begin
                        s_cnt_q <= '0;
                        if (rx_smp) begin
                            // Line came back high: treat as a glitch
                            state_q     <= S_IDLE;
                            active_flag <= 1'b0;
                            done_flag   <= 1'b1;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_q   <= '0;
                        shift_q   <= {rx_smp, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= par_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_q   <= '0;
                        par_bit_q <= rx_smp;
                        state_q   <= S_STOP;
                    end else begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_q      <= '0;
                        data_out     <= shift_q;
                        parity_error <= par_en & (par_bit_q != par_exp);
                        frame_error  <= ~rx_smp;
                        data_valid   <= 1'b1;
                        // A low stop bit may be a break: require idle high before rearming
                        if (!rx_smp) begin
                            armed_q <= 1'b0;
                        end
                        state_q     <= S_IDLE;
                        active_flag <= 1'b0;
                        done_flag   <= 1'b1;
                    end else begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// tb/tb_uart_sipo_rx.sv - scoreboard testbench for uart_sipo_rx
module tb_uart_sipo_rx;

    localparam int OS = 16;

    logic       baud_clk;
    logic       reset_n;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         lat;
        int         t0;
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] last_byte;
    bit         pulse_chk;

    uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
        .baud_clk     (baud_clk),
        .reset_n      (reset_n),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: compares every data_valid pulse against the oldest expectation
    always @(negedge baud_clk) begin
        if (pulse_chk) begin
            chk_eq("dv_one_cycle", data_valid, 1'b0);
            pulse_chk = 1'b0;
        end
        if (data_valid) begin
            chk_eq("dv_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("data_out", data_out, e.d);
                chk_eq("parity_error", parity_error, e.pe);
                chk_eq("frame_error", frame_error, e.fe);
                chk_eq("latency", cyc - e.t0, e.lat);
                last_byte = e.d;
            end
            pulse_chk = 1'b1;
        end
    end

    task automatic idle(input int n);
        data_rx = 1'b1;
        repeat (n) @(negedge baud_clk);
    endtask

    // Drives one frame from a negedge; glitch_bit flips one cycle centred on that bit's sample
    task automatic send_frame(input logic [7:0] b, input bit par_on, input logic pbit,
                              input logic [7:0] exp_d, input logic exp_pe, input logic exp_fe,
                              input int stop_cycles, input int glitch_bit);
        exp_t e;
        e.d   = exp_d;
        e.pe  = exp_pe;
        e.fe  = exp_fe;
        e.lat = par_on ? 3 + OS/2 + OS*10 : 3 + OS/2 + OS*9;
        e.t0  = cyc;
        data_rx = 1'b0;
        sb.push_back(e);
        repeat (OS) @(negedge baud_clk);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < OS; c++) begin
                data_rx = b[i] ^ ((i == glitch_bit) && (c == OS/2));
                @(negedge baud_clk);
            end
        end
        if (par_on) begin
            data_rx = pbit;
            repeat (OS) @(negedge baud_clk);
        end
        data_rx = 1'b1;
        repeat (stop_cycles) @(negedge baud_clk);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge baud_clk);
            n++;
        end
        chk_eq(tag, sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_data_out"}, data_out, 8'h00);
        chk_eq({tag, "_dv"}, data_valid, 1'b0);
        chk_eq({tag, "_pe"}, parity_error, 1'b0);
        chk_eq({tag, "_fe"}, frame_error, 1'b0);
        chk_eq({tag, "_active"}, active_flag, 1'b0);
        chk_eq({tag, "_done"}, done_flag, 1'b1);
    endtask

    initial begin
        logic [7:0] hold_byte;
        logic [7:0] rst_byte;
        logic [7:0] mv_exp;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_byte   = 8'h00;
        pulse_chk   = 1'b0;
        reset_n     = 1'b0;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(negedge baud_clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        idle(5);

        // Clean no-parity byte
        send_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, OS, -1);
        idle(4);
        wait_drain("drain_a5");
        chk_eq("a5_active", active_flag, 1'b0);
        chk_eq("a5_done", done_flag, 1'b1);

        // Parity: even ok, even bad, odd ok
        parity_type = 2'b10;
        send_frame(8'h03, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, OS, -1);
        idle(4);
        send_frame(8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, OS, -1);
        idle(4);
        parity_type = 2'b01;
        send_frame(8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, OS, -1);
        idle(4);
        wait_drain("drain_parity");

        // Back-to-back: next start edge lands one cycle after the stop sample
        parity_type = 2'b00;
        send_frame(8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 9, -1);
        send_frame(8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, OS, -1);
        idle(4);
        wait_drain("drain_b2b");

        // Start glitch: short low pulse is rejected
        hold_byte = last_byte;
        data_rx = 1'b0;
        repeat (4) @(negedge baud_clk);
        chk_eq("glitch_active_hi", active_flag, 1'b1);
        idle(30);
        chk_eq("glitch_active_lo", active_flag, 1'b0);
        chk_eq("glitch_done", done_flag, 1'b1);
        chk_eq("glitch_data_hold", data_out, hold_byte);

        // Break: one framing-error frame, then nothing until the line returns high
        e_break: begin
            exp_t e;
            e.d   = 8'h00;
            e.pe  = 1'b0;
            e.fe  = 1'b1;
            e.lat = 3 + OS/2 + OS*9;
            e.t0  = cyc;
            data_rx = 1'b0;
            sb.push_back(e);
            repeat (20*OS) @(negedge baud_clk);
        end
        wait_drain("drain_break");
        chk_eq("break_fe_hold", frame_error, 1'b1);
        idle(20);
        send_frame(8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, OS, -1);
        idle(4);
        wait_drain("drain_5a");

        // Reset during data bit 4 discards the partial frame
        rst_byte = 8'h3C;
        data_rx = 1'b0;
        repeat (OS) @(negedge baud_clk);
        for (int i = 0; i < 4; i++) begin
            data_rx = rst_byte[i];
            repeat (OS) @(negedge baud_clk);
        end
        data_rx = rst_byte[4];
        repeat (OS/2) @(negedge baud_clk);
        reset_n = 1'b0;
        data_rx = 1'b1;
        repeat (3) @(negedge baud_clk);
        chk_reset_outputs("midreset");
        reset_n = 1'b1;
        idle(5);
        send_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, OS, -1);
        idle(4);
        wait_drain("drain_3c");

        // One-cycle high pulse centred on the bit-2 sample point
`ifdef RX_MAJORITY_VOTE_EN
        mv_exp = 8'h00;
`else
        mv_exp = 8'h04;
`endif
        send_frame(8'h00, 1'b0, 1'b0, mv_exp, 1'b0, 1'b0, OS, 2);
        idle(4);
        wait_drain("drain_vote");

        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
